// File: rtl/line_draw_sequencer_pkg.sv
// Shared types and constants for the line draw sequencer and its endpoint mux.
package line_draw_sequencer_pkg;

    // Sequencer states; one edge walks LOAD -> CLEAR -> START -> DRAW.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_START = 3'd3,
        S_DRAW  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Edge indices: which vertex pair feeds the datapath.
    localparam logic [1:0] EDGE_01 = 2'd0;
    localparam logic [1:0] EDGE_12 = 2'd1;
    localparam logic [1:0] EDGE_20 = 2'd2;

    // Default per-edge DRAW cycle limit before the watchdog aborts the edge.
    localparam int unsigned TIMEOUT_DEFAULT = 1048575;

endpackage

// File: rtl/line_edge_select.sv
// Registered endpoint mux: captures the endpoint pair of the selected edge
// when i_load pulses and holds it stable until the next load.
module line_edge_select
    import line_draw_sequencer_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [1:0]       i_edge,
    input  logic [WIDTH-1:0] i_v0x,
    input  logic [WIDTH-1:0] i_v0y,
    input  logic [WIDTH-1:0] i_v1x,
    input  logic [WIDTH-1:0] i_v1y,
    input  logic [WIDTH-1:0] i_v2x,
    input  logic [WIDTH-1:0] i_v2y,
    output logic [WIDTH-1:0] o_x0,
    output logic [WIDTH-1:0] o_y0,
    output logic [WIDTH-1:0] o_x1,
    output logic [WIDTH-1:0] o_y1
);

    logic [WIDTH-1:0] r_x0;
    logic [WIDTH-1:0] r_y0;
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_y1;

    // Capture the selected vertex pair on load; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
        end else if (i_load) begin
            case (i_edge)
                EDGE_01: begin
                    r_x0 <= i_v0x;
                    r_y0 <= i_v0y;
                    r_x1 <= i_v1x;
                    r_y1 <= i_v1y;
                end
                EDGE_12: begin
                    r_x0 <= i_v1x;
                    r_y0 <= i_v1y;
                    r_x1 <= i_v2x;
                    r_y1 <= i_v2y;
                end
                default: begin
                    r_x0 <= i_v2x;
                    r_y0 <= i_v2y;
                    r_x1 <= i_v0x;
                    r_y1 <= i_v0y;
                end
            endcase
        end
    end

    assign o_x0 = r_x0;
    assign o_y0 = r_y0;
    assign o_x1 = r_x1;
    assign o_y1 = r_y1;

endmodule

// File: rtl/line_draw_sequencer.sv
// Control sequencer for the line drawing datapath: accepts a line or triangle
// request and walks the datapath through load/clear/start/draw for each edge.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both high. req_ready is high only in IDLE (and
// never while rst is high); a request held valid while not ready is neither
// taken nor dropped, it transfers on the first IDLE cycle.
module line_draw_sequencer
    import line_draw_sequencer_pkg::*;
#(
    parameter int          WIDTH   = 10,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_tri,
    input  logic [WIDTH-1:0] v0x,
    input  logic [WIDTH-1:0] v0y,
    input  logic [WIDTH-1:0] v1x,
    input  logic [WIDTH-1:0] v1y,
    input  logic [WIDTH-1:0] v2x,
    input  logic [WIDTH-1:0] v2y,
    input  logic             fb_ready,
    input  logic             finish,
    output logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] y1,
    output logic             en_Precomputed,
    output logic             rst_Precomputed,
    output logic             rst_fragment,
    output logic             start_fragment,
    output logic             en_FB_reg,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [1:0]       edge_idx,
    output state_t           dbg_state
);

    // Watchdog sizing; a zero TIMEOUT keeps a 1-bit counter that never expires.
    localparam int             WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit             WD_EN   = (TIMEOUT != 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [1:0]       r_edge;
    logic [1:0]       r_last;
    logic [WD_W-1:0]  r_wd;
    logic             r_timeout_err;
    logic             r_en_pre;
    logic             r_clr;
    logic             r_start;
    logic             r_done;
    logic             r_busy;
    logic [WIDTH-1:0] r_v0x;
    logic [WIDTH-1:0] r_v0y;
    logic [WIDTH-1:0] r_v1x;
    logic [WIDTH-1:0] r_v1y;
    logic [WIDTH-1:0] r_v2x;
    logic [WIDTH-1:0] r_v2y;

    logic             w_accept;
    logic             w_expire;
    logic             w_edge_end;
    logic             w_is_last;
    logic             w_sel_load;
    logic [1:0]       w_sel_edge;
    logic [WIDTH-1:0] w_sel_v0x;
    logic [WIDTH-1:0] w_sel_v0y;
    logic [WIDTH-1:0] w_sel_v1x;
    logic [WIDTH-1:0] w_sel_v1y;
    logic [WIDTH-1:0] w_sel_v2x;
    logic [WIDTH-1:0] w_sel_v2y;

    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_expire   = WD_EN && (r_wd == WD_LAST);
    assign w_edge_end = (r_state == S_DRAW) && (finish || w_expire);
    assign w_is_last  = (r_edge == r_last);

    // Endpoint mux load: on accept use the incoming vertices so endpoints are
    // ready in LOAD; on a non-last edge end use the latched vertices.
    always_comb begin
        w_sel_load = 1'b0;
        w_sel_edge = EDGE_01;
        w_sel_v0x  = r_v0x;
        w_sel_v0y  = r_v0y;
        w_sel_v1x  = r_v1x;
        w_sel_v1y  = r_v1y;
        w_sel_v2x  = r_v2x;
        w_sel_v2y  = r_v2y;
        if (w_accept) begin
            w_sel_load = 1'b1;
            w_sel_v0x  = v0x;
            w_sel_v0y  = v0y;
            w_sel_v1x  = v1x;
            w_sel_v1y  = v1y;
            w_sel_v2x  = v2x;
            w_sel_v2y  = v2y;
        end else if (w_edge_end && !w_is_last) begin
            w_sel_load = 1'b1;
            w_sel_edge = r_edge + 2'd1;
        end
    end

    // Sequencer FSM, watchdog and registered control pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_edge        <= EDGE_01;
            r_last        <= EDGE_01;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
            r_en_pre      <= 1'b0;
            r_clr         <= 1'b0;
            r_start       <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_v0x         <= '0;
            r_v0y         <= '0;
            r_v1x         <= '0;
            r_v1y         <= '0;
            r_v2x         <= '0;
            r_v2y         <= '0;
        end else begin
            r_en_pre <= 1'b0;
            r_clr    <= 1'b0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_v0x         <= v0x;
                        r_v0y         <= v0y;
                        r_v1x         <= v1x;
                        r_v1y         <= v1y;
                        r_v2x         <= v2x;
                        r_v2y         <= v2y;
                        r_edge        <= EDGE_01;
                        r_last        <= req_tri ? EDGE_20 : EDGE_01;
                        r_timeout_err <= 1'b0;
                        r_en_pre      <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_clr   <= 1'b1;
                    r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_start <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    r_wd <= r_wd + 1'b1;
                    if (finish || w_expire) begin
                        // finish wins over a coincident expiry
                        if (!finish) begin
                            r_timeout_err <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_edge   <= r_edge + 2'd1;
                            r_en_pre <= 1'b1;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    line_edge_select #(
        .WIDTH (WIDTH)
    ) u_edge_select (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_sel_load),
        .i_edge (w_sel_edge),
        .i_v0x  (w_sel_v0x),
        .i_v0y  (w_sel_v0y),
        .i_v1x  (w_sel_v1x),
        .i_v1y  (w_sel_v1y),
        .i_v2x  (w_sel_v2x),
        .i_v2y  (w_sel_v2y),
        .o_x0   (x0),
        .o_y0   (y0),
        .o_x1   (x1),
        .o_y1   (y1)
    );

    assign req_ready       = (r_state == S_IDLE) && !rst;
    assign busy            = r_busy;
    assign done            = r_done;
    assign timeout_err     = r_timeout_err;
    assign edge_idx        = r_edge;
    assign en_Precomputed  = r_en_pre;
    assign rst_Precomputed = rst;
    assign rst_fragment    = rst | r_clr;
    assign start_fragment  = r_start;
    assign en_FB_reg       = (r_state == S_DRAW) && fb_ready && !rst;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_line_draw_sequencer.sv
// Bench for line_draw_sequencer: directed primitives, with a monitor that
// checks edge endpoints at each start pulse and timeout status at each done.
module tb_line_draw_sequencer;
  import line_draw_sequencer_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_tri = 1'b0;
  logic [W-1:0] v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic         fb_ready = 1'b1;
  logic         finish = 1'b0;
  logic [W-1:0] x0, y0, x1, y1;
  logic         en_Precomputed, rst_Precomputed, rst_fragment, start_fragment;
  logic         en_FB_reg, busy, done, timeout_err;
  logic [1:0]   edge_idx;
  state_t       dbg_state;

  int tests_run = 0;
  int fails = 0;

  logic [41:0] exp_q[$];
  logic [0:0]  exp_done_q[$];
  logic [41:0] exp_e;
  logic [0:0]  exp_d;

  // clock / reset
  always #5 clk = ~clk;

  line_draw_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tri(req_tri), .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y),
    .v2x(v2x), .v2y(v2y), .fb_ready(fb_ready), .finish(finish),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .en_Precomputed(en_Precomputed), .rst_Precomputed(rst_Precomputed),
    .rst_fragment(rst_fragment), .start_fragment(start_fragment),
    .en_FB_reg(en_FB_reg), .busy(busy), .done(done),
    .timeout_err(timeout_err), .edge_idx(edge_idx), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] erec(input logic [1:0] e, input logic [W-1:0] a, b, c, d);
    return {e, a, b, c, d};
  endfunction

  // expected endpoint records for a primitive, in edge order
  task automatic push_edges(input logic t, input logic [W-1:0] a0x, a0y, a1x, a1y, a2x, a2y, input int n);
    exp_q.push_back(erec(EDGE_01, a0x, a0y, a1x, a1y));
    if (t && n > 1) exp_q.push_back(erec(EDGE_12, a1x, a1y, a2x, a2y));
    if (t && n > 2) exp_q.push_back(erec(EDGE_20, a2x, a2y, a0x, a0y));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && start_fragment) begin
      if (exp_q.size() == 0) begin
        tests_run++; fails++;
        $display("FAIL edge_unexpected: got start_fragment with edge %0d, expected none", edge_idx);
      end else begin
        exp_e = exp_q.pop_front();
        check("edge_endpoints", {22'd0, edge_idx, x0, y0, x1, y1}, {22'd0, exp_e});
      end
    end
    if (!rst && done) begin
      if (exp_done_q.size() == 0) begin
        tests_run++; fails++;
        $display("FAIL done_unexpected: got done=1, expected no done");
      end else begin
        exp_d = exp_done_q.pop_front();
        check("done_timeout_err", {63'd0, timeout_err}, {63'd0, exp_d});
      end
    end
  end

  // driver tasks: called just after a rising edge; return just after one
  task automatic send_req(input logic t, input logic [W-1:0] a0x, a0y, a1x, a1y, a2x, a2y);
    int n = 0;
    req_valid = 1'b1; req_tri = t;
    v0x = a0x; v0y = a0y; v1x = a1x; v1y = a1y; v2x = a2x; v2y = a2y;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    check("req_ready_at_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_edge(input logic [41:0] rec, input int ndraw, input bit do_fin,
                          input logic [7:0] fbpat, input bit stray, input logic exp_terr);
    if (stray) finish = 1'b1;
    @(negedge clk);
    check("load_en_pre", {63'd0, en_Precomputed}, 64'd1);
    check("load_state", {61'd0, dbg_state}, {61'd0, S_LOAD});
    check("load_endpoints", {22'd0, edge_idx, x0, y0, x1, y1}, {22'd0, rec});
    check("load_timeout_err", {63'd0, timeout_err}, {63'd0, exp_terr});
    check("load_req_ready", {63'd0, req_ready}, 64'd0);
    check("load_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    check("clear_rst_fragment", {63'd0, rst_fragment}, 64'd1);
    check("clear_en_pre", {63'd0, en_Precomputed}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_pulse", {63'd0, start_fragment}, 64'd1);
    check("start_rst_fragment", {63'd0, rst_fragment}, 64'd0);
    for (int i = 0; i < ndraw; i++) begin
      @(posedge clk); #1;
      fb_ready = fbpat[i];
      finish = do_fin && (i == ndraw - 1);
      @(negedge clk);
      check("draw_state", {61'd0, dbg_state}, {61'd0, S_DRAW});
      check("draw_en_fb", {63'd0, en_FB_reg}, {63'd0, fbpat[i]});
      check("draw_start_low", {63'd0, start_fragment}, 64'd0);
      check("draw_edge_idx", {62'd0, edge_idx}, {62'd0, rec[41:40]});
    end
    @(posedge clk); #1;
    finish = 1'b0;
    fb_ready = 1'b1;
  endtask

  task automatic expect_done(input logic exp_terr);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("done_state", {61'd0, dbg_state}, {61'd0, S_DONE});
    check("done_req_ready", {63'd0, req_ready}, 64'd0);
    check("done_timeout_err", {63'd0, timeout_err}, {63'd0, exp_terr});
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_done_low", {63'd0, done}, 64'd0);
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  // time limit
  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, expected finish", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    // reset
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rst_pre", {63'd0, rst_Precomputed}, 64'd1);
    check("rst_rst_frag", {63'd0, rst_fragment}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outputs", {52'd0, done, timeout_err, edge_idx, en_Precomputed, start_fragment, en_FB_reg, x0[0], y0[0], x1[0], y1[0], 1'b0},
          64'd0);
    check("rst_endpoints", {24'd0, x0, y0, x1, y1}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_rst_pre", {63'd0, rst_Precomputed}, 64'd0);
    check("post_rst_state", {61'd0, dbg_state}, {61'd0, S_IDLE});
    @(posedge clk); #1;

    // single line (10,20)->(15,22), finish on the 6th DRAW cycle
    push_edges(1'b0, 10'd10, 10'd20, 10'd15, 10'd22, 10'd0, 10'd0, 1);
    exp_done_q.push_back(1'b0);
    send_req(1'b0, 10'd10, 10'd20, 10'd15, 10'd22, 10'd0, 10'd0);
    run_edge(erec(EDGE_01, 10'd10, 10'd20, 10'd15, 10'd22), 6, 1'b1, 8'hFF, 1'b0, 1'b0);
    expect_done(1'b0);

    // triangle (0,0),(100,0),(50,80)
    push_edges(1'b1, 10'd0, 10'd0, 10'd100, 10'd0, 10'd50, 10'd80, 3);
    exp_done_q.push_back(1'b0);
    send_req(1'b1, 10'd0, 10'd0, 10'd100, 10'd0, 10'd50, 10'd80);
    run_edge(erec(EDGE_01, 10'd0, 10'd0, 10'd100, 10'd0), 3, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_edge(erec(EDGE_12, 10'd100, 10'd0, 10'd50, 10'd80), 2, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_edge(erec(EDGE_20, 10'd50, 10'd80, 10'd0, 10'd0), 1, 1'b1, 8'hFF, 1'b0, 1'b0);
    expect_done(1'b0);

    // backpressure: fb_ready 1,0,0,1 then finish with fb_ready 1
    push_edges(1'b0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0, 1);
    exp_done_q.push_back(1'b0);
    send_req(1'b0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0);
    run_edge(erec(EDGE_01, 10'd1, 10'd2, 10'd3, 10'd4), 5, 1'b1, 8'b0001_1001, 1'b0, 1'b0);
    expect_done(1'b0);

    // watchdog: no finish, edge aborted after 8 DRAW cycles
    push_edges(1'b0, 10'd5, 10'd5, 10'd9, 10'd9, 10'd0, 10'd0, 1);
    exp_done_q.push_back(1'b1);
    send_req(1'b0, 10'd5, 10'd5, 10'd9, 10'd9, 10'd0, 10'd0);
    run_edge(erec(EDGE_01, 10'd5, 10'd5, 10'd9, 10'd9), 8, 1'b0, 8'hFF, 1'b0, 1'b0);
    expect_done(1'b1);
    @(negedge clk);
    check("timeout_err_sticky", {63'd0, timeout_err}, 64'd1);
    @(posedge clk); #1;

    // degenerate line with stray finish in LOAD; clears timeout_err;
    // a second request is held valid from LOAD and taken after DONE
    push_edges(1'b0, 10'd7, 10'd7, 10'd7, 10'd7, 10'd0, 10'd0, 1);
    exp_done_q.push_back(1'b0);
    send_req(1'b0, 10'd7, 10'd7, 10'd7, 10'd7, 10'd0, 10'd0);
    push_edges(1'b0, 10'd20, 10'd30, 10'd40, 10'd50, 10'd0, 10'd0, 1);
    exp_done_q.push_back(1'b0);
    req_valid = 1'b1; req_tri = 1'b0;
    v0x = 10'd20; v0y = 10'd30; v1x = 10'd40; v1y = 10'd50;
    run_edge(erec(EDGE_01, 10'd7, 10'd7, 10'd7, 10'd7), 1, 1'b1, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    check("held_done_pulse", {63'd0, done}, 64'd1);
    check("held_not_ready_in_done", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_ready_in_idle", {63'd0, req_ready}, 64'd1);
    check("held_idle_state", {61'd0, dbg_state}, {61'd0, S_IDLE});
    @(posedge clk); #1;
    req_valid = 1'b0;
    run_edge(erec(EDGE_01, 10'd20, 10'd30, 10'd40, 10'd50), 2, 1'b1, 8'hFF, 1'b0, 1'b0);
    expect_done(1'b0);

    // reset during DRAW of triangle edge 1
    push_edges(1'b1, 10'd1, 10'd1, 10'd30, 10'd1, 10'd15, 10'd20, 2);
    send_req(1'b1, 10'd1, 10'd1, 10'd30, 10'd1, 10'd15, 10'd20);
    run_edge(erec(EDGE_01, 10'd1, 10'd1, 10'd30, 10'd1), 2, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_edge(erec(EDGE_12, 10'd30, 10'd1, 10'd15, 10'd20), 2, 1'b0, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rst_pre", {63'd0, rst_Precomputed}, 64'd1);
    check("midrst_rst_frag", {63'd0, rst_fragment}, 64'd1);
    check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", {61'd0, dbg_state}, {61'd0, S_IDLE});
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_edge_idx", {62'd0, edge_idx}, 64'd0);
    check("midrst_req_ready_after", {63'd0, req_ready}, 64'd1);
    check("midrst_endpoints", {24'd0, x0, y0, x1, y1}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end

    // everything expected was seen
    check("edge_queue_empty", exp_q.size(), 64'd0);
    check("done_queue_empty", exp_done_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
